// File: rtl/trig_sched_pkg.sv
// ---------------------------------------------------------------------------
// trig_sched_pkg
//   Shared definitions for the trigger command scheduler.
//   - state_e   : FSM state encoding (IDLE / ISSUE / GAP). The fourth code is
//                 unused and recovers to IDLE.
//   - wrap_inc  : modulo-n increment used to advance the round-robin pointer.
// ---------------------------------------------------------------------------
package trig_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    // Increment idx, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/trig_cmd_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin selector.
//   Ports:
//     req     in  N    request vector
//     ptr     in  IDW  index that has highest priority this round
//     gnt_id  out IDW  first set request at or above ptr, wrapping to 0
//     gnt_any out 1    at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_any
);

    // hi_mask marks positions ptr..N-1. Requests in that window win first;
    // if the window is empty the search wraps and the lowest request wins.
    logic [N-1:0] hi_mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] search;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign hi_mask[gi] = (IDW'(gi) >= ptr);
        end
    endgenerate

    assign req_hi  = req & hi_mask;
    assign search  = (|req_hi) ? req_hi : req;
    assign gnt_any = |req;

    // Lowest set bit of the selected window; scan from the top so the
    // lowest index is assigned last.
    always_comb begin
        gnt_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (search[k]) begin
                gnt_id = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/trig_cmd_scheduler.sv
// ---------------------------------------------------------------------------
// trig_cmd_scheduler
//   Latches one-cycle trigger pulses as pending requests and hands them one
//   at a time to a shared command consumer over valid/ready, choosing among
//   simultaneous requests round-robin. After each accepted command a quiet
//   gap of GAP cycles is enforced before the next command may issue.
//   Ports:
//     clk        in   1    system clock, rising edge
//     rst        in   1    asynchronous active-low reset
//     btn_trig   in   N    single-cycle trigger pulses, one per requester
//     cmd_ready  in   1    consumer accepts when cmd_valid && cmd_ready
//     cmd_valid  out  1    command presented
//     cmd_id     out  IDW  requester being served
//     overrun    out  N    1-cycle pulse: trigger lost, bit already pending
//     busy       out  1    FSM not idle or any request pending
//   All outputs come straight from flops.
// ---------------------------------------------------------------------------
module trig_cmd_scheduler
    import trig_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int GAP = 1000,
    parameter int GW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   btn_trig,
    input  logic           cmd_ready,
    output logic           cmd_valid,
    output logic [IDW-1:0] cmd_id,
    output logic [N-1:0]   overrun,
    output logic           busy
);

    state_e         state_q,     state_d;
    logic [N-1:0]   pending_q,   pending_d;
    logic [N-1:0]   overrun_q,   overrun_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic [IDW-1:0] cmd_id_q,    cmd_id_d;
    logic [IDW-1:0] ptr_q,       ptr_d;
    logic [GW-1:0]  cnt_q,       cnt_d;
    logic           busy_q,      busy_d;

    logic           handshake;
    logic [N-1:0]   clr;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;

    assign handshake = cmd_valid_q & cmd_ready;

    // One-hot clear for the requester whose command is accepted this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_clr
            assign clr[gi] = handshake && (cmd_id_q == IDW'(gi));
        end
    endgenerate

    // A new trigger beats the clear of the same bit, so a pulse landing on
    // the handshake cycle is kept as a fresh request. A trigger on a bit
    // that stays pending is reported as lost.
    assign pending_d = btn_trig | (pending_q & ~clr);
    assign overrun_d = btn_trig & pending_q & ~clr;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req     (pending_q),
        .ptr     (ptr_q),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_id_d    = cmd_id_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    cmd_id_d    = gnt_id;
                    cmd_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // cmd_id is frozen here; only the handshake moves us on.
                if (handshake) begin
                    cmd_valid_d = 1'b0;
                    ptr_d       = IDW'(wrap_inc(int'(cmd_id_q), N));
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GW'(GAP - 1);
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase

        // Registered busy reflects the state and pending set we move into.
        busy_d = (state_d != S_IDLE) || (|pending_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            overrun_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_id_q    <= cmd_id_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_id    = cmd_id_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
